// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST sequencer.
// Holds the FSM state enum, core latency, LFSR/MISR taps and the LFSR step helper.
package c17_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int          CUT_LATENCY = 2;
    localparam logic [4:0]  LFSR_TAPS   = 5'b10100;
    localparam logic [15:0] MISR_TAPS   = 16'h1021;

    // x^5+x^3+1, shift left, feedback into bit 0
    function automatic logic [4:0] lfsr_next(input logic [4:0] s);
        return {s[3:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// Multiple-input signature register compacting the 2-bit core response.
// Ports: clk, reset, clr_i (sync clear), en_i (update), data_i[1:0], sig_o.
module c17_bist_misr
    import c17_bist_pkg::*;
#(
    parameter int MISR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [1:0]        data_i,
    output logic [MISR_W-1:0] sig_o
);

    localparam logic [MISR_W-1:0] TAPS = MISR_TAPS[MISR_W-1:0];

    logic [MISR_W-1:0] misr_q;
    logic [MISR_W-1:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clr_i) begin
            misr_d = '0;
        end else if (en_i) begin
            misr_d = {misr_q[MISR_W-2:0], 1'b0}
                   ^ (misr_q[MISR_W-1] ? TAPS : '0)
                   ^ {{(MISR_W-2){1'b0}}, data_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig_o = misr_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the registered c17 core: drives patterns, compacts responses, checks signature.
// Ports: clk, reset, start, abort, cut_in[4:0], cut_out[1:0], busy, done, pass, signature, pat_idx[9:0].
// Build option: C17_BIST_EXHAUSTIVE_EN swaps the LFSR for a 0..31 up-counter over 32 patterns.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int              NUM_PATTERNS = 31,
    parameter logic [4:0]      SEED         = 5'b00001,
    parameter int              MISR_W       = 16,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        cut_in,
    input  logic [1:0]        cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [9:0]        pat_idx
);

`ifdef C17_BIST_EXHAUSTIVE_EN
    localparam int         NPAT     = 32;
    localparam logic [4:0] SEED_EFF = 5'd0;

    function automatic logic [4:0] pat_next(input logic [4:0] p);
        return p + 5'd1;
    endfunction
`else
    localparam int         NPAT     = NUM_PATTERNS;
    localparam logic [4:0] SEED_EFF = (SEED == 5'd0) ? 5'd1 : SEED;

    function automatic logic [4:0] pat_next(input logic [4:0] p);
        return lfsr_next(p);
    endfunction
`endif

    localparam logic [9:0] LAST_IDX = 10'(NPAT - 1);
    localparam logic [1:0] LAST_DRN = 2'(CUT_LATENCY - 1);

    state_t     state_q, state_d;
    logic [4:0] pat_q, pat_d;
    logic [9:0] idx_q, idx_d;
    logic [1:0] drn_q, drn_d;
    logic [1:0] vld_q, vld_d;
    logic       pass_q, pass_d;
    logic       misr_clr;
    logic       abort_hit;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        drn_d    = drn_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        // vld_q[1] marks the cycle whose cut_out belongs to a driven pattern
        vld_d    = {vld_q[0], state_q == RUN};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    pat_d    = SEED_EFF;
                    idx_d    = '0;
                    pass_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                    vld_d   = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end else begin
                    pat_d = pat_next(pat_q);
                    idx_d = idx_q + 10'd1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                    vld_d   = '0;
                end else if (drn_q == LAST_DRN) begin
                    state_d = DONE;
                end else begin
                    drn_d = drn_q + 2'd1;
                end
            end
            DONE: begin
                pass_d  = (signature == GOLDEN_SIG);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            drn_q   <= '0;
            vld_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            drn_q   <= drn_d;
            vld_q   <= vld_d;
            pass_q  <= pass_d;
        end
    end

    // An aborted run leaves the signature exactly as it was
    assign abort_hit = abort & busy;

    c17_bist_misr #(
        .MISR_W (MISR_W)
    ) u_misr (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (misr_clr),
        .en_i   (vld_q[1] & ~abort_hit),
        .data_i (cut_out),
        .sig_o  (signature)
    );

    assign cut_in  = pat_q;
    assign pat_idx = idx_q;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign pass    = pass_q;

endmodule
